// File: rtl/confused_io_ctrl.sv
// I/O controller between the ConfusedCore datapath and the off-chip parallel peripheral.
// Optional flash checksum output enabled by `define CONFUSED_FLASH_CKSUM_EN.
module confused_io_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ROM_AW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inputReady,
  output logic              inputWaiting,
  input  logic [DATA_W-1:0] parallelIn,
  output logic [DATA_W-1:0] parallelOut,
  output logic              outValid,
  input  logic              flashEnable,
  input  logic              rdReq,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  input  logic              wrReq,
  input  logic [DATA_W-1:0] wrData,
  output logic              IObusy,
  output logic              romWe,
  output logic [ROM_AW-1:0] romAddr,
  output logic [DATA_W-1:0] romWd,
  output logic              flashDone,
`ifdef CONFUSED_FLASH_CKSUM_EN
  output logic [DATA_W-1:0] flashSum,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [ROM_AW-1:0] ROM_LAST = {ROM_AW{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLASH = 2'd1,
    ST_FDONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_fe_q;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [DATA_W-1:0] r_par_out;
  logic              r_out_valid;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_fe_rise;
  logic w_enter_flash;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == FULL_CNT);
  assign w_fe_rise     = flashEnable & ~r_fe_q;
  assign w_enter_flash = (r_state == ST_RUN) & w_fe_rise;

  // Handshakes: a peripheral word transfers on a cycle where inputReady & inputWaiting;
  // a core read completes (and pops) on a cycle where rdValid, otherwise IObusy holds the core.
  always_comb begin
    w_next_state = r_state;
    inputWaiting = 1'b0;
    rdValid      = 1'b0;
    IObusy       = 1'b1;
    romWe        = 1'b0;
    flashDone    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_RUN: begin
        inputWaiting = ~w_full;
        w_push       = inputReady & ~w_full;
        w_pop        = rdReq & ~w_empty;
        rdValid      = w_pop;
        IObusy       = rdReq & w_empty;
        if (w_fe_rise) w_next_state = ST_FLASH;
      end
      ST_FLASH: begin
        inputWaiting = 1'b1;
        romWe        = inputReady;
        if (!flashEnable || (inputReady && (r_rom_addr == ROM_LAST)))
          w_next_state = ST_FDONE;
      end
      ST_FDONE: begin
        flashDone    = 1'b1;
        w_next_state = ST_RUN;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_fe_q  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_fe_q  <= flashEnable;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= parallelIn;
  end

  // Flash entry discards anything queued, including a word arriving that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_enter_flash) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Address wraps naturally after the last location.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rom_addr <= '0;
    end else if (w_enter_flash) begin
      r_rom_addr <= '0;
    end else if (romWe) begin
      r_rom_addr <= r_rom_addr + ROM_AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= wrReq;
      if (wrReq) r_par_out <= wrData;
    end
  end

`ifdef CONFUSED_FLASH_CKSUM_EN
  logic [DATA_W-1:0] r_flash_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flash_sum <= '0;
    end else if (w_enter_flash) begin
      r_flash_sum <= '0;
    end else if (romWe) begin
      r_flash_sum <= r_flash_sum + parallelIn;
    end
  end

  assign flashSum = r_flash_sum;
`endif

  assign rdData      = r_mem[r_rd_ptr];
  assign parallelOut = r_par_out;
  assign outValid    = r_out_valid;
  assign romAddr     = r_rom_addr;
  assign romWd       = parallelIn;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_confused_io_ctrl.sv
// Directed bench for confused_io_ctrl (ROM_AW=2 so the flash wrap is reachable).
module tb_confused_io_ctrl;

  logic        clk;
  logic        reset;
  logic        inputReady;
  logic        inputWaiting;
  logic [15:0] parallelIn;
  logic [15:0] parallelOut;
  logic        outValid;
  logic        flashEnable;
  logic        rdReq;
  logic [15:0] rdData;
  logic        rdValid;
  logic        wrReq;
  logic [15:0] wrData;
  logic        IObusy;
  logic        romWe;
  logic [1:0]  romAddr;
  logic [15:0] romWd;
  logic        flashDone;
`ifdef CONFUSED_FLASH_CKSUM_EN
  logic [15:0] flashSum;
`endif
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  confused_io_ctrl #(.DATA_W(16), .ROM_AW(2), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inputReady   (inputReady),
    .inputWaiting (inputWaiting),
    .parallelIn   (parallelIn),
    .parallelOut  (parallelOut),
    .outValid     (outValid),
    .flashEnable  (flashEnable),
    .rdReq        (rdReq),
    .rdData       (rdData),
    .rdValid      (rdValid),
    .wrReq        (wrReq),
    .wrData       (wrData),
    .IObusy       (IObusy),
    .romWe        (romWe),
    .romAddr      (romAddr),
    .romWd        (romWd),
    .flashDone    (flashDone),
`ifdef CONFUSED_FLASH_CKSUM_EN
    .flashSum     (flashSum),
`endif
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_rd [3];

    reset       = 1'b0;
    inputReady  = 1'b0;
    parallelIn  = '0;
    flashEnable = 1'b0;
    rdReq       = 1'b0;
    wrReq       = 1'b0;
    wrData      = '0;

    // Reset state
    #2;
    check("rst_state",   dbg_state, 0);
    check("rst_waiting", inputWaiting, 1);
    check("rst_pout",    parallelOut, 0);
    check("rst_ovalid",  outValid, 0);
    check("rst_romwe",   romWe, 0);
    check("rst_romaddr", romAddr, 0);
    check("rst_fdone",   flashDone, 0);
    check("rst_busy",    IObusy, 0);
    check("rst_rdvalid", rdValid, 0);
`ifdef CONFUSED_FLASH_CKSUM_EN
    check("rst_fsum",    flashSum, 0);
`endif
    tick;
    tick;
    reset = 1'b1;
    tick;

    // In-order FIFO reads
    exp_rd[0] = 16'h0011;
    exp_rd[1] = 16'h0022;
    exp_rd[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      inputReady = 1'b1;
      parallelIn = exp_rd[i];
      tick;
    end
    inputReady = 1'b0;
    rdReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fifo_rdvalid", rdValid, 1);
      check("fifo_rddata",  rdData, exp_rd[i]);
      check("fifo_busy",    IObusy, 0);
      tick;
    end
    rdReq = 1'b0;

    // Read stall on empty FIFO, word arrives 5 cycles later
    rdReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        inputReady = 1'b1;
        parallelIn = 16'hBEEF;
      end
      #1;
      check("stall_busy",    IObusy, 1);
      check("stall_rdvalid", rdValid, 0);
      tick;
    end
    inputReady = 1'b0;
    #1;
    check("stall_done_rdvalid", rdValid, 1);
    check("stall_done_rddata",  rdData, 16'hBEEF);
    check("stall_done_busy",    IObusy, 0);
    tick;
    rdReq = 1'b0;

    // Fill FIFO, refuse 5th, pop reopens, pop+push at same time
    for (int i = 0; i < 4; i++) begin
      inputReady = 1'b1;
      parallelIn = 16'h0100 + 16'(i);
      tick;
    end
    inputReady = 1'b0;
    #1;
    check("full_waiting", inputWaiting, 0);
    inputReady = 1'b1;
    parallelIn = 16'hDEAD;
    tick;
    inputReady = 1'b0;
    check("full_still_waiting", inputWaiting, 0);
    rdReq = 1'b1;
    #1;
    check("full_pop_data",    rdData, 16'h0100);
    check("full_pop_waiting", inputWaiting, 0);
    tick;
    rdReq = 1'b0;
    #1;
    check("after_pop_waiting", inputWaiting, 1);
    rdReq      = 1'b1;
    inputReady = 1'b1;
    parallelIn = 16'h0200;
    #1;
    check("pushpop_rdvalid", rdValid, 1);
    check("pushpop_rddata",  rdData, 16'h0101);
    tick;
    inputReady = 1'b0;
    exp_rd[0] = 16'h0102;
    exp_rd[1] = 16'h0103;
    exp_rd[2] = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain_rdvalid", rdValid, 1);
      check("drain_rddata",  rdData, exp_rd[i]);
      tick;
    end
    rdReq = 1'b0;
    #1;
    check("drain_empty_busy", IObusy, 0);

    // Core write, and write concurrent with read
    wrReq  = 1'b1;
    wrData = 16'hA5A5;
    #1;
    check("wr_nostall", IObusy, 0);
    tick;
    wrReq = 1'b0;
    check("wr_pout",   parallelOut, 16'hA5A5);
    check("wr_ovalid", outValid, 1);
    tick;
    check("wr_ovalid_drop", outValid, 0);
    check("wr_pout_hold",   parallelOut, 16'hA5A5);
    inputReady = 1'b1;
    parallelIn = 16'h0077;
    tick;
    inputReady = 1'b0;
    rdReq  = 1'b1;
    wrReq  = 1'b1;
    wrData = 16'h5A5A;
    #1;
    check("rdwr_rdvalid", rdValid, 1);
    check("rdwr_rddata",  rdData, 16'h0077);
    tick;
    rdReq = 1'b0;
    wrReq = 1'b0;
    check("rdwr_pout",   parallelOut, 16'h5A5A);
    check("rdwr_ovalid", outValid, 1);

    // Flash three words then drop flashEnable; queued word is flushed
    inputReady = 1'b1;
    parallelIn = 16'h0099;
    tick;
    inputReady  = 1'b0;
    flashEnable = 1'b1;
    tick;
    check("fl_state",   dbg_state, 1);
    check("fl_busy",    IObusy, 1);
    check("fl_waiting", inputWaiting, 1);
    check("fl_addr0",   romAddr, 0);
    check("fl_fdone",   flashDone, 0);
    for (int k = 1; k <= 3; k++) begin
      inputReady = 1'b1;
      parallelIn = 16'(k);
      #1;
      check("fl_romwe",   romWe, 1);
      check("fl_romaddr", romAddr, 32'(k - 1));
      check("fl_romwd",   romWd, 32'(k));
      tick;
    end
    inputReady  = 1'b0;
    flashEnable = 1'b0;
    #1;
    check("fl_idle_romwe", romWe, 0);
    tick;
    check("fdone_state",   dbg_state, 2);
    check("fdone_pulse",   flashDone, 1);
    check("fdone_waiting", inputWaiting, 0);
    check("fdone_busy",    IObusy, 1);
`ifdef CONFUSED_FLASH_CKSUM_EN
    check("fdone_fsum", flashSum, 6);
`endif
    tick;
    check("run_state", dbg_state, 0);
    check("run_fdone", flashDone, 0);
`ifdef CONFUSED_FLASH_CKSUM_EN
    check("run_fsum_hold", flashSum, 6);
`endif
    rdReq = 1'b1;
    #1;
    check("flushed_busy",    IObusy, 1);
    check("flushed_rdvalid", rdValid, 0);

    // Flash wrap at ROM_AW=2 with a pending read and a core write during flash
    flashEnable = 1'b1;
    tick;
    check("wrap_state", dbg_state, 1);
    for (int i = 0; i < 4; i++) begin
      inputReady = 1'b1;
      parallelIn = 16'd10 + 16'(i);
      wrReq      = (i == 1);
      wrData     = 16'h1234;
      #1;
      check("wrap_romwe",   romWe, 1);
      check("wrap_romaddr", romAddr, 32'(i));
      check("wrap_busy",    IObusy, 1);
      check("wrap_rdvalid", rdValid, 0);
      if (i == 2) begin
        check("wrap_pout",   parallelOut, 16'h1234);
        check("wrap_ovalid", outValid, 1);
      end
      tick;
    end
    wrReq      = 1'b0;
    parallelIn = 16'd14;
    #1;
    check("wrap_fdone_state", dbg_state, 2);
    check("wrap_refused",     romWe, 0);
    check("wrap_waiting",     inputWaiting, 0);
    check("wrap_addr",        romAddr, 0);
    check("wrap_fdone",       flashDone, 1);
    check("wrap_fdone_busy",  IObusy, 1);
`ifdef CONFUSED_FLASH_CKSUM_EN
    check("wrap_fsum", flashSum, 16'h002E);
`endif
    inputReady = 1'b0;
    tick;
    check("wrap_run_state", dbg_state, 0);
    check("wrap_run_busy",  IObusy, 1);
    check("wrap_run_rdval", rdValid, 0);
    tick;
    check("no_retrigger", dbg_state, 0);
    rdReq = 1'b0;

    // Asynchronous reset in the middle of a flash write
    flashEnable = 1'b0;
    tick;
    flashEnable = 1'b1;
    tick;
    check("mid_state", dbg_state, 1);
    inputReady = 1'b1;
    parallelIn = 16'h0055;
    #1;
    check("mid_romwe", romWe, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_romwe",   romWe, 0);
    check("mid_rst_state",   dbg_state, 0);
    check("mid_rst_romaddr", romAddr, 0);
    check("mid_rst_fdone",   flashDone, 0);
    check("mid_rst_pout",    parallelOut, 0);
    check("mid_rst_ovalid",  outValid, 0);
`ifdef CONFUSED_FLASH_CKSUM_EN
    check("mid_rst_fsum", flashSum, 0);
`endif
    inputReady  = 1'b0;
    flashEnable = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    check("post_rst_state",   dbg_state, 0);
    check("post_rst_waiting", inputWaiting, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
